// File: rtl/adma_dm_rd_atx_gen.sv
// adma_dm_rd_atx_gen: splits a read descriptor (channel, address, beat count) into AXI INCR bursts
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   req_chn_id/req_addr/req_beats      descriptor, handshaked by req_vld/req_rdy
//   atx_chn_id/atx_arid/atx_araddr     burst descriptor to the read host,
//   atx_arlen/atx_arburst              handshaked by atx_vld/atx_rdy
//   req_done                           one-cycle pulse once the whole descriptor has been issued
// Macro ADMA_ATXG_4K_BOUND_EN: when defined, bursts are additionally clipped so none crosses a 4 KB boundary.
module adma_dm_rd_atx_gen #(
  parameter int DMA_CHN_NUM    = 4,
  parameter int SRC_ADDR_W     = 32,
  parameter int ATX_SRC_DATA_W = 256,
  parameter int MST_ID_W       = 5,
  parameter int ATX_LEN_W      = 8,
  parameter int ATX_MAX_BEAT   = 16,
  parameter int DMA_LEN_W      = 16,
  localparam int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DMA_CHN_NUM_W-1:0] req_chn_id,
  input  logic [SRC_ADDR_W-1:0]    req_addr,
  input  logic [DMA_LEN_W-1:0]     req_beats,
  input  logic                     req_vld,
  output logic                     req_rdy,
  output logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
  output logic [MST_ID_W-1:0]      atx_arid,
  output logic [SRC_ADDR_W-1:0]    atx_araddr,
  output logic [ATX_LEN_W-1:0]     atx_arlen,
  output logic [1:0]               atx_arburst,
  output logic                     atx_vld,
  input  logic                     atx_rdy,
  output logic                     req_done
);
  localparam int BYTE_AMT = ATX_SRC_DATA_W / 8;
  localparam int OFS      = $clog2(BYTE_AMT);
  localparam int BB_W     = $clog2(ATX_MAX_BEAT) + 1;
  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;
  state_t state, state_nxt;
  logic [DMA_CHN_NUM_W-1:0] chn_q;
  logic [SRC_ADDR_W-1:0]    addr_q;
  logic [DMA_LEN_W-1:0]     rem_q;
  logic [ATX_LEN_W-1:0]     arlen_q;
  logic                     done_q;
  logic [BB_W-1:0]          rem_cap;
  logic [BB_W-1:0]          bb_c;
  logic                     req_hs;
  logic                     atx_hs;
  logic                     last;
  assign req_rdy     = state == IDLE;
  assign atx_vld     = state == ISSUE;
  assign req_hs      = req_vld & req_rdy;
  assign atx_hs      = atx_vld & atx_rdy;
  // The burst length is carried as arlen; the beat count of the current burst is arlen+1.
  assign last        = rem_q == DMA_LEN_W'(arlen_q) + DMA_LEN_W'(1);
  assign atx_chn_id  = chn_q;
  assign atx_arid    = MST_ID_W'(chn_q);
  assign atx_araddr  = addr_q;
  assign atx_arlen   = arlen_q;
  assign atx_arburst = 2'b01;
  assign req_done    = done_q;
  assign rem_cap = (rem_q < DMA_LEN_W'(ATX_MAX_BEAT)) ? rem_q[BB_W-1:0] : BB_W'(ATX_MAX_BEAT);
`ifdef ADMA_ATXG_4K_BOUND_EN
  logic [12:0] to_4k;
  logic [12:0] b4k;
  // addr_q is beat-aligned, so the byte distance to the next 4 KB page divides exactly.
  assign to_4k = 13'h1000 - {1'b0, addr_q[11:0]};
  assign b4k   = to_4k >> OFS;
  assign bb_c  = (b4k < 13'(rem_cap)) ? b4k[BB_W-1:0] : rem_cap;
`else
  assign bb_c  = rem_cap;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (req_hs && req_beats != '0) ? CALC : IDLE;
      CALC:    state_nxt = ISSUE;
      ISSUE:   state_nxt = atx_hs ? (last ? IDLE : CALC) : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      chn_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      arlen_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (req_hs && req_beats == '0) || (atx_hs && last);
      if (req_hs) begin
        chn_q  <= req_chn_id;
        addr_q <= req_addr & ~SRC_ADDR_W'(BYTE_AMT - 1);
        rem_q  <= req_beats;
      end
      if (state == CALC) arlen_q <= ATX_LEN_W'(bb_c - BB_W'(1));
      if (atx_hs) begin
        addr_q <= addr_q + ((SRC_ADDR_W'(arlen_q) + SRC_ADDR_W'(1)) << OFS);
        rem_q  <= rem_q - (DMA_LEN_W'(arlen_q) + DMA_LEN_W'(1));
      end
    end
  end
endmodule

// File: tb/tb_adma_dm_rd_atx_gen.sv
// tb_adma_dm_rd_atx_gen: scoreboard bench for the read burst generator
module tb_adma_dm_rd_atx_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_chn_id;
  logic [31:0] req_addr;
  logic [15:0] req_beats;
  logic        req_vld;
  logic        req_rdy;
  logic [1:0]  atx_chn_id;
  logic [4:0]  atx_arid;
  logic [31:0] atx_araddr;
  logic [7:0]  atx_arlen;
  logic [1:0]  atx_arburst;
  logic        atx_vld;
  logic        atx_rdy;
  logic        req_done;
  typedef struct {
    logic [1:0]  chn;
    logic [31:0] addr;
    logic [7:0]  arlen;
    bit          last;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit zero_due = 1'b0;
  bit done_due = 1'b0;
  bit prev_stall = 1'b0;
  logic [31:0] p_addr;
  logic [7:0]  p_len;
  logic [1:0]  p_chn;
  logic [4:0]  p_id;
  adma_dm_rd_atx_gen dut (
    .clk(clk), .rst(rst),
    .req_chn_id(req_chn_id), .req_addr(req_addr), .req_beats(req_beats),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .atx_chn_id(atx_chn_id), .atx_arid(atx_arid), .atx_araddr(atx_araddr),
    .atx_arlen(atx_arlen), .atx_arburst(atx_arburst),
    .atx_vld(atx_vld), .atx_rdy(atx_rdy), .req_done(req_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic push(input logic [1:0] c, input logic [31:0] a, input logic [7:0] l, input bit lst);
    exp_t e;
    e.chn = c; e.addr = a; e.arlen = l; e.last = lst;
    q.push_back(e);
  endtask
  // Monitor: pops the expected burst on every accepted burst, checks stall stability and req_done timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_due = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (done_due || (req_done && !zero_due)) chk("req_done_timing", req_done, done_due);
        done_due = 1'b0;
        if (prev_stall) begin
          chk("stall_vld", atx_vld, 1);
          chk("stall_addr", atx_araddr, p_addr);
          chk("stall_len", atx_arlen, p_len);
          chk("stall_chn", atx_chn_id, p_chn);
          chk("stall_id", atx_arid, p_id);
        end
        if (atx_vld && atx_rdy) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_burst actual addr=%0h len=%0h required none", atx_araddr, atx_arlen);
          end else begin
            e = q.pop_front();
            chk("atx_araddr", atx_araddr, e.addr);
            chk("atx_arlen", atx_arlen, e.arlen);
            chk("atx_chn_id", atx_chn_id, e.chn);
            chk("atx_arid", atx_arid, {3'b000, e.chn});
            chk("atx_arburst", atx_arburst, 2'b01);
            done_due = e.last;
          end
        end
        prev_stall = atx_vld && !atx_rdy;
        p_addr = atx_araddr; p_len = atx_arlen; p_chn = atx_chn_id; p_id = atx_arid;
      end
    end
  end
  task automatic send(input logic [1:0] c, input logic [31:0] a, input logic [15:0] b);
    int n = 0;
    req_chn_id = c; req_addr = a; req_beats = b; req_vld = 1'b1;
    while (!req_rdy && n < 200) begin @(posedge clk); #1; n++; end
    if (!req_rdy) chk("req_rdy_timeout", req_rdy, 1);
    @(posedge clk); #1;
    req_vld = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !req_rdy) && n < 300) begin @(posedge clk); #1; n++; end
    chk("drain_timeout", q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask
  task automatic wait_vld();
    int n = 0;
    while (!atx_vld && n < 20) begin @(posedge clk); #1; n++; end
    chk("vld_timeout", atx_vld, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; req_vld = 1'b0; req_chn_id = '0; req_addr = '0; req_beats = '0; atx_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_atx_vld", atx_vld, 0);
    chk("rst_req_done", req_done, 0);
    chk("rst_arid", atx_arid, 0);
    chk("rst_araddr", atx_araddr, 0);
    chk("rst_arlen", atx_arlen, 0);
    chk("rst_chn", atx_chn_id, 0);
    chk("rst_arburst", atx_arburst, 2'b01);
    @(posedge clk); #1;
    rst = 1'b0;
    push(1, 32'h1000, 15, 0); push(1, 32'h1200, 15, 0); push(1, 32'h1400, 7, 1);
    send(1, 32'h1000, 40);
    chk("lat_calc_vld", atx_vld, 0);
    @(posedge clk); #1;
    chk("lat_issue_vld", atx_vld, 1);
    wait_idle();
`ifdef ADMA_ATXG_4K_BOUND_EN
    push(2, 32'h1FC0, 1, 0); push(2, 32'h2000, 2, 1);
`else
    push(2, 32'h1FC0, 4, 1);
`endif
    send(2, 32'h1FC0, 5);
    wait_idle();
    zero_due = 1'b1;
    send(3, 32'h80, 0);
    chk("zero_done", req_done, 1);
    chk("zero_rdy", req_rdy, 1);
    chk("zero_vld", atx_vld, 0);
    @(posedge clk); #1;
    zero_due = 1'b0;
    chk("zero_done_pulse", req_done, 0);
    chk("zero_vld2", atx_vld, 0);
    push(1, 32'h1000, 0, 1);
    send(1, 32'h101F, 1);
    wait_idle();
    atx_rdy = 1'b0;
    push(2, 32'h40, 2, 1);
    send(2, 32'h40, 3);
    wait_vld();
    repeat (5) begin @(posedge clk); #1; end
    chk("stall5_vld", atx_vld, 1);
    atx_rdy = 1'b1;
    wait_idle();
    push(3, 32'h0, 0, 1);
    send(3, 32'h0, 1);
    wait_idle();
`ifdef ADMA_ATXG_4K_BOUND_EN
    push(0, 32'hFFFF_FFE0, 0, 0); push(0, 32'h0, 0, 1);
`else
    push(0, 32'hFFFF_FFE0, 1, 1);
`endif
    send(0, 32'hFFFF_FFE0, 2);
    wait_idle();
    push(1, 32'h100, 0, 1);
    push(2, 32'h200, 1, 1);
    send(1, 32'h100, 1);
    send(2, 32'h200, 2);
    wait_idle();
    atx_rdy = 1'b0;
    send(0, 32'h1000, 40);
    wait_vld();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_vld", atx_vld, 0);
    chk("mid_rst_rdy", req_rdy, 1);
    chk("mid_rst_done", req_done, 0);
    chk("mid_rst_addr", atx_araddr, 0);
    atx_rdy = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    chk("post_rst_vld", atx_vld, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adma_dm_rd_atx_gen.md
ADMA_DM_RD_ATX_GEN -- requirements
Module: adma_dm_rd_atx_gen

Interface
REQ-001 SHALL have parameter DMA_CHN_NUM, default 4, number of DMA channels; DMA_CHN_NUM_W = clog2(DMA_CHN_NUM), minimum 1.
REQ-002 SHALL have parameters SRC_ADDR_W=32 (address width), ATX_SRC_DATA_W=256 (beat width; BYTE_AMT=ATX_SRC_DATA_W/8), MST_ID_W=5 (AXI ID width), ATX_LEN_W=8 (arlen width).
REQ-003 SHALL have parameters ATX_MAX_BEAT=16 (burst beat cap, power of 2, at most 2^ATX_LEN_W) and DMA_LEN_W=16 (descriptor beat-count width).
REQ-004 SHALL have ports clk in 1 (single clock) and rst in 1 (reset: synchronous, active-high).
REQ-005 req_chn_id in DMA_CHN_NUM_W / req_addr in SRC_ADDR_W / req_beats in DMA_LEN_W: descriptor (channel, start address, total beats).
REQ-006 req_vld in 1 / req_rdy out 1: descriptor handshake.
REQ-007 atx_chn_id out DMA_CHN_NUM_W / atx_arid out MST_ID_W / atx_araddr out SRC_ADDR_W / atx_arlen out ATX_LEN_W / atx_arburst out 2: burst descriptor to rd host.
REQ-008 atx_vld out 1 / atx_rdy in 1: burst handshake to rd host.
REQ-009 req_done out 1: one-cycle pulse, descriptor fully issued.

Function
REQ-010 SHALL implement FSM IDLE, CALC, ISSUE; req_rdy=1 only in IDLE; atx_vld=1 only in ISSUE.
REQ-011 IDLE: on req_vld&req_rdy, capture chn_id, addr (low log2(BYTE_AMT) bits forced to 0), beats; beats!=0 -> CALC; beats==0 -> stay IDLE, req_done=1 next cycle, no burst.
REQ-012 CALC: register burst_beats = min(remaining, ATX_MAX_BEAT, beats_to_4k), beats_to_4k = (4096 - addr[11:0])/BYTE_AMT; -> ISSUE.
REQ-013 ISSUE: atx_arlen=burst_beats-1, atx_arburst=2'b01 (INCR), atx_arid=chn_id zero-extended to MST_ID_W, atx_chn_id=chn_id, atx_araddr=current addr.
REQ-014 ISSUE outputs SHALL hold stable while atx_vld&!atx_rdy.
REQ-015 On atx_vld&atx_rdy: addr += burst_beats*BYTE_AMT (wraps mod 2^SRC_ADDR_W), remaining -= burst_beats; remaining==0 -> IDLE with req_done=1 next cycle; else -> CALC.
REQ-016 Latency: descriptor handshake at cycle N -> first atx_vld at N+2; each subsequent burst 2 cycles after previous acceptance.
REQ-017 req_done SHALL be asserted only in the cycle after the final burst handshake or the zero-length capture; new descriptor accepted in that same cycle (FSM already IDLE).
REQ-018 Registered outputs only; no combinational path req_* -> atx_* or atx_rdy -> req_rdy.

Reset
REQ-019 rst=1 at a clock edge SHALL force IDLE, req_rdy=1, atx_vld=0, req_done=0, atx_arid/araddr/arlen/chn_id=0, atx_arburst=2'b01, remaining=0, regardless of state; in-flight descriptor dropped.
REQ-020 rst SHALL take priority over any handshake in the same cycle.

Configuration
REQ-021 Macro ADMA_ATXG_4K_BOUND_EN defined: beats_to_4k term SHALL apply in CALC, no burst crosses a 4 KB boundary.
REQ-022 Macro undefined: burst_beats = min(remaining, ATX_MAX_BEAT); 4 KB logic absent.

Verification (defaults, BYTE_AMT=32, macro defined unless stated)
REQ-023 addr 0x1000, beats 40, atx_rdy=1 -> bursts (0x1000, arlen 15), (0x1200, 15), (0x1400, 7); req_done one cycle after third accept.
REQ-024 addr 0x1FC0, beats 5 -> (0x1FC0, arlen 1), (0x2000, arlen 2); macro undefined -> single (0x1FC0, arlen 4).
REQ-025 beats 0 -> atx_vld never asserted; req_done pulses one cycle after handshake; req_rdy stays 1.
REQ-026 atx_rdy held 0 for 5 cycles during ISSUE -> atx_vld=1, all atx_* unchanged throughout, accept on 6th cycle.
REQ-027 rst=1 for one cycle mid-ISSUE of 40-beat descriptor -> next cycle atx_vld=0, req_rdy=1, req_done=0; no further bursts.
REQ-028 req_chn_id 3, addr 0x0, beats 1 -> atx_chn_id 3, atx_arid 5'd3, arlen 0, arburst 2'b01.
